lc3_mem_responder: RTL and testbench
====================================

// Module: lc3_mem_responder
// PURPOSE
//  Cycle-accurate instruction + data memory for the LC3 pipeline; sits directly upstream of Fetch
//  (serves instrmem_rd/pc) and beside MemAccess (serves Data_rd/Data_addr). Replaces zero-latency
//  behavioural memory with a configurable-latency handshake, so controller stall paths
//  (complete_instr/complete_data low) are exercised.
// PARAMETERS
//  ADDR_W     8        index width of each array; depth = 2**ADDR_W words of 16 bits
//  BASE_ADDR  16'h3000 PC mapped to instruction index 0
//  INSTR_LAT  1        cycles from request sample to complete_instr (legal range 1..15)
//  DATA_LAT   1        cycles from request sample to complete_data (legal range 1..15)
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-high reset
//  instrmem_rd     in   1   instruction fetch request from Fetch
//  pc              in   16  fetch address
//  Instr_dout      out  16  fetched instruction
//  complete_instr  out  1   one-cycle fetch-done strobe
//  Data_rd         in   1   data read request
//  Data_wr         in   1   data write request
//  Data_addr       in   16  data address; low ADDR_W bits index the data array
//  Data_din        in   16  write data
//  Data_dout       out  16  read data
//  complete_data   out  1   one-cycle data-done strobe
//  ld_en           in   1   preload write strobe
//  ld_sel          in   1   0 = instruction array, 1 = data array
//  ld_addr         in   ADDR_W  preload index
//  ld_data         in   16  preload word
//  oob_err         out  1   sticky: a fetch fell outside the instruction array
//  col_err         out  1   sticky: Data_rd and Data_wr were sampled high together
//  instr_count     out  16  completed fetches; wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset values: Instr_dout = 0, Data_dout = 0, complete_* = 0, oob_err = 0, col_err = 0,
//   instr_count = 0, both FSMs in IDLE. Arrays are not cleared.
//  Per-port FSM states IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: when the request is sampled high, capture address/data, load cnt = LAT-1, go WAIT,
//    or go straight to RESP when LAT = 1.
//   WAIT: decrement cnt each cycle; at 0 go RESP.
//   RESP: complete = 1 and dout valid for exactly this cycle; return to IDLE. No request is
//    sampled in RESP.
//  Latency: request sampled at edge N -> complete high in the cycle after edge N+LAT-1.
//   Throughput is one access per LAT+1 cycles.
//  Address and din are captured at the sample edge; changes during WAIT are ignored.
//  Dropping the request mid-WAIT does not cancel the access: it completes normally.
//  Instruction index = (pc - BASE_ADDR) mod 2^16. If index >= 2**ADDR_W, return 16'h0000
//   (BR never-taken = NOP) and set oob_err.
//  Data write: commit to the array on the RESP cycle; Data_dout holds its old value.
//  Data read: returns the array word as of the RESP cycle.
//  Data_rd and Data_wr sampled together: the read proceeds, the write is dropped, col_err is set.
//  Instr_dout and Data_dout hold their last value after complete falls.
//  Preload: accepted every clock edge, including while reset is high. A preload to the same
//   index as a RESP-cycle data write wins.
//  instr_count increments on each RESP of the instruction port.
//  Asserting reset mid-transaction: immediate return to IDLE, complete = 0, no array write.
// CONFIGURATION
//  LC3_MEM_STALL_EN defined:
//   - 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advances on each request
//     sample of either port.
//   - The captured lfsr[1:0] adds 0..3 extra WAIT cycles to that transaction.
//  Undefined: fixed latency exactly INSTR_LAT/DATA_LAT; no LFSR logic is present.
// STRUCTURE
//  Package lc3_mem_pkg:
//   - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t
//   - localparam NOP_INSTR = 16'h0000
//   - LFSR seed/tap constants
//  Sub-module lc3_mem_port_fsm (params LAT; ports req, extra[1:0], fire, busy, complete),
//   instantiated once per port. The arrays and muxing stay in the top.
// TESTING
//  1. INSTR_LAT=1; preload idx0=16'h1021; pc=16'h3000, instrmem_rd=1 -> complete_instr
//     1 cycle later, Instr_dout=16'h1021, instr_count=1.
//  2. DATA_LAT=3; Data_wr addr 5 din 16'hBEEF, then Data_rd addr 5 -> complete_data 3 cycles
//     after each sample, Data_dout=16'hBEEF.
//  3. pc=16'h3000+256 with ADDR_W=8 -> Instr_dout=16'h0000 and oob_err=1, held until reset.
//  4. Data_rd=Data_wr=1 on addr 2 (preloaded 16'h0007) -> Data_dout=16'h0007, word unchanged,
//     col_err=1.
//  5. INSTR_LAT=4; reset asserted 2 cycles after the sample -> complete_instr never pulses,
//     FSM IDLE; the next fetch completes normally.
//  6. LC3_MEM_STALL_EN: first fetch after reset (seed 8'hA5, lfsr[1:0]=2'b01) completes at
//     INSTR_LAT+1 cycles; the same test without the macro completes at INSTR_LAT.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 instruction/data memory responder.
package lc3_mem_pkg;

    // Per-port handshake state: accept a request, count down latency, strobe completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Returned for fetches outside the instruction array: BR never-taken, i.e. a NOP.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Latency counter width: LAT-1 (max 14) plus up to 3 stall cycles.
    localparam int CNT_W = 5;

    // Stall LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Fetch and MemAccess request/response bus between the LC3 pipeline and its memory.
interface lc3_mem_responder_if;

    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] Instr_dout;
    logic        complete_instr;

    logic        Data_rd;
    logic        Data_wr;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;

    // Pipeline side: issues fetch and data requests.
    modport master (
        output instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din,
        input  Instr_dout, complete_instr, Data_dout, complete_data
    );

    // Memory side: answers them after the configured latency.
    modport slave (
        input  instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din,
        output Instr_dout, complete_instr, Data_dout, complete_data
    );

endinterface

// File: rtl/lc3_mem_port_fsm.sv
// One memory port's handshake: IDLE -> (WAIT) -> RESP -> IDLE.
// fire pulses combinationally in the cycle a request is accepted so the parent can capture
// address/data on that edge; complete is high for exactly the RESP cycle.
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] extra,
    output logic       fire,
    output logic       busy,
    output logic       complete
);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

    // Remaining WAIT cycles after the accept edge, including any injected stall.
    assign load_val = CNT_W'(LAT - 1) + CNT_W'(extra);

    // State and countdown registers; reset abandons any access in flight.
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and strobes; requests are only looked at in IDLE.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fire     = 1'b0;
        busy     = (state_q != IDLE);
        complete = (state_q == RESP);
        case (state_q)
            IDLE: begin
                if (req) begin
                    fire = 1'b1;
                    if (load_val == '0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = load_val;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Cycle-accurate instruction + data memory for the LC3 pipeline with handshake latency.
// Optional feature: define LC3_MEM_STALL_EN to add 0..3 pseudo-random WAIT cycles per
// transaction from an 8-bit LFSR that advances on every accepted request.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] BASE_ADDR = 16'h3000,
    parameter int          INSTR_LAT = 1,
    parameter int          DATA_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    lc3_mem_responder_if.slave bus,
    input  logic              ld_en,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic              oob_err,
    output logic              col_err,
    output logic [15:0]       instr_count
);

    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [15:0] imem [DEPTH];
    logic [15:0] dmem [DEPTH];

    logic       i_fire, i_busy, i_complete;
    logic       d_fire, d_busy, d_complete;
    logic [1:0] i_extra, d_extra;

    // Captured request state, frozen from the accept edge until RESP.
    logic [ADDR_W-1:0] i_idx_q;
    logic              i_oob_q;
    logic [15:0]       i_hold_q;
    logic [ADDR_W-1:0] d_idx_q;
    logic [15:0]       d_din_q;
    logic              d_wr_q;
    logic [15:0]       d_hold_q;

    logic [15:0] i_index;
    logic        i_oob;

    // Only the low ADDR_W data-address bits select a word; busy is for external observers.
    wire unused_addr_hi = ^bus.Data_addr[15:ADDR_W];
    wire unused_busy    = i_busy ^ d_busy;

    assign i_index = bus.pc - BASE_ADDR;
    assign i_oob   = ({1'b0, i_index} >= DEPTH_W);

    lc3_mem_port_fsm #(.LAT(INSTR_LAT)) u_instr_fsm (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.instrmem_rd),
        .extra    (i_extra),
        .fire     (i_fire),
        .busy     (i_busy),
        .complete (i_complete)
    );

    lc3_mem_port_fsm #(.LAT(DATA_LAT)) u_data_fsm (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.Data_rd | bus.Data_wr),
        .extra    (d_extra),
        .fire     (d_fire),
        .busy     (d_busy),
        .complete (d_complete)
    );

`ifdef LC3_MEM_STALL_EN
    logic [7:0] lfsr_q;

    // Stall generator: one step per accept edge, shared by both ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (i_fire || d_fire) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign i_extra = lfsr_q[1:0];
    assign d_extra = lfsr_q[1:0];
`else
    assign i_extra = 2'b00;
    assign d_extra = 2'b00;
`endif

    // Outputs show the live array word during RESP and hold the last result otherwise.
    assign bus.complete_instr = i_complete;
    assign bus.Instr_dout     = i_complete ? (i_oob_q ? NOP_INSTR : imem[i_idx_q]) : i_hold_q;
    assign bus.complete_data  = d_complete;
    assign bus.Data_dout      = (d_complete && !d_wr_q) ? dmem[d_idx_q] : d_hold_q;

    // Instruction port: capture the fetch index, flag out-of-range fetches, count completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_idx_q     <= '0;
            i_oob_q     <= 1'b0;
            i_hold_q    <= '0;
            oob_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (i_fire) begin
                i_idx_q <= i_index[ADDR_W-1:0];
                i_oob_q <= i_oob;
                if (i_oob) begin
                    oob_err <= 1'b1;
                end
            end
            if (i_complete) begin
                i_hold_q    <= bus.Instr_dout;
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    // Data port: capture address/data; a simultaneous read+write keeps the read only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_idx_q  <= '0;
            d_din_q  <= '0;
            d_wr_q   <= 1'b0;
            d_hold_q <= '0;
            col_err  <= 1'b0;
        end else begin
            if (d_fire) begin
                d_idx_q <= bus.Data_addr[ADDR_W-1:0];
                d_din_q <= bus.Data_din;
                d_wr_q  <= bus.Data_wr & ~bus.Data_rd;
                if (bus.Data_wr && bus.Data_rd) begin
                    col_err <= 1'b1;
                end
            end
            if (d_complete) begin
                d_hold_q <= bus.Data_dout;
            end
        end
    end

    // Array writes: data commit on RESP, then preload, so a same-index preload wins.
    // NOTE: the arrays are deliberately outside the reset domain; preload works during reset.
    always_ff @(posedge clk) begin
        if (d_complete && d_wr_q && !reset) begin
            dmem[d_idx_q] <= d_din_q;
        end
        if (ld_en) begin
            if (ld_sel) begin
                dmem[ld_addr] <= ld_data;
            end else begin
                imem[ld_addr] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: drivers push expected responses (value and the cycle
// they are due), a negedge monitor pops and compares whenever a completion is due or seen.
// Instance A: INSTR_LAT=1, DATA_LAT=3. Instance B: INSTR_LAT=4 (reset-abort scenario).
module tb_lc3_mem_responder;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 256;
    localparam logic [15:0] BASE   = 16'h3000;
    localparam int          A_ILAT = 1;
    localparam int          A_DLAT = 3;
    localparam int          B_ILAT = 4;
    localparam int          B_DLAT = 2;

`ifdef LC3_MEM_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] dout;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic              ld_en, ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_data;
    logic        oob_a, col_a, oob_b, col_b;
    logic [15:0] cnt_a, cnt_b;

    lc3_mem_responder_if bus_a ();
    lc3_mem_responder_if bus_b ();

    lc3_mem_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .INSTR_LAT(A_ILAT), .DATA_LAT(A_DLAT)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .oob_err(oob_a), .col_err(col_a), .instr_count(cnt_a)
    );

    lc3_mem_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .INSTR_LAT(B_ILAT), .DATA_LAT(B_DLAT)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .oob_err(oob_b), .col_err(col_b), .instr_count(cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [15:0] imem_m [DEPTH];
    logic [15:0] dmem_m [DEPTH];
    exp_t        sb [3][$];      // 0: A fetch, 1: A data, 2: B fetch
    int          fetch_n [2];
    bit          oob_m [2];
    bit          col_m;
    logic [15:0] last_rd;
    int          lfsr_m [2];
    int          last_edge [2];
    int          cur_x [2];
    int          b_pulses = 0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Extra stall cycles for a request sampled at edge_n; both ports share one step per edge.
    function automatic int take_extra(input int inst, input int edge_n);
        int fb;
        if (edge_n != last_edge[inst]) begin
            cur_x[inst]     = lfsr_m[inst] & 3;
            fb              = ((lfsr_m[inst] >> 7) ^ (lfsr_m[inst] >> 5) ^
                               (lfsr_m[inst] >> 4) ^ (lfsr_m[inst] >> 3)) & 1;
            lfsr_m[inst]    = ((lfsr_m[inst] << 1) | fb) & 8'hFF;
            last_edge[inst] = edge_n;
        end
        return STALL_EN ? cur_x[inst] : 0;
    endfunction

    task automatic reset_model(input int inst);
        lfsr_m[inst]    = 8'hA5;
        last_edge[inst] = -1;
        fetch_n[inst]   = 0;
        oob_m[inst]     = 1'b0;
        if (inst == 0) begin
            col_m   = 1'b0;
            last_rd = 16'h0000;
        end
    endtask

    task automatic mon(input int p, input logic comp, input logic [15:0] dout, input string tag);
        bit exp_comp;
        exp_comp = (sb[p].size() != 0) && (sb[p][0].due == cyc);
        if (comp || exp_comp) begin
            check({tag, "_complete"}, 32'(comp), 32'(exp_comp));
            if (exp_comp) begin
                check({tag, "_dout"}, 32'(dout), 32'(sb[p][0].dout));
                void'(sb[p].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.complete_instr, bus_a.Instr_dout, "a_fetch");
        mon(1, bus_a.complete_data, bus_a.Data_dout, "a_data");
        mon(2, bus_b.complete_instr, bus_b.Instr_dout, "b_fetch");
        if (bus_b.complete_instr === 1'b1) b_pulses <= b_pulses + 1;
    end

    // Preload one word; called and returns one time unit after a rising edge.
    task automatic preload(input logic sel, input int idx, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = ADDR_W'(idx);
        ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (sel) dmem_m[idx] = d;
        else     imem_m[idx] = d;
    endtask

    function automatic logic icomp(input int inst);
        return (inst == 0) ? bus_a.complete_instr : bus_b.complete_instr;
    endfunction

    task automatic fetch(input int inst, input logic [15:0] pc);
        logic [15:0] idx;
        exp_t        e;
        bit          done;
        @(posedge clk); #1;
        idx    = pc - BASE;
        e.due  = cyc + ((inst == 0) ? A_ILAT : B_ILAT) + take_extra(inst, cyc + 1);
        e.dout = (int'(idx) >= DEPTH) ? 16'h0000 : imem_m[idx[ADDR_W-1:0]];
        if (int'(idx) >= DEPTH) oob_m[inst] = 1'b1;
        fetch_n[inst]++;
        sb[(inst == 0) ? 0 : 2].push_back(e);
        if (inst == 0) begin bus_a.instrmem_rd = 1'b1; bus_a.pc = pc; end
        else           begin bus_b.instrmem_rd = 1'b1; bus_b.pc = pc; end
        @(posedge clk); #1;
        // Request dropped and address scrambled while the access is in flight.
        if (inst == 0) begin bus_a.instrmem_rd = 1'b0; bus_a.pc = 16'($urandom); end
        else           begin bus_b.instrmem_rd = 1'b0; bus_b.pc = 16'($urandom); end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = icomp(inst);
        end
        check($sformatf("fetch%0d_done", inst), 32'(done), 32'(1));
        @(negedge clk);
        check($sformatf("fetch%0d_count", inst), 32'((inst == 0) ? cnt_a : cnt_b), 32'(16'(fetch_n[inst])));
        check($sformatf("fetch%0d_oob_err", inst), 32'((inst == 0) ? oob_a : oob_b), 32'(oob_m[inst]));
    endtask

    task automatic data_op(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
        int   idx;
        exp_t e;
        bit   done;
        @(posedge clk); #1;
        idx   = int'(addr[ADDR_W-1:0]);
        e.due = cyc + A_DLAT + take_extra(0, cyc + 1);
        if (rd) begin
            e.dout  = dmem_m[idx];
            last_rd = e.dout;
        end else begin
            e.dout      = last_rd;
            dmem_m[idx] = din;
        end
        if (rd && wr) col_m = 1'b1;
        sb[1].push_back(e);
        bus_a.Data_rd   = rd;
        bus_a.Data_wr   = wr;
        bus_a.Data_addr = addr;
        bus_a.Data_din  = din;
        @(posedge clk); #1;
        bus_a.Data_rd   = 1'b0;
        bus_a.Data_wr   = 1'b0;
        bus_a.Data_addr = 16'($urandom);
        bus_a.Data_din  = 16'($urandom);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = bus_a.complete_data;
        end
        check("data_done", 32'(done), 32'(1));
        @(negedge clk);
        check("data_col_err", 32'(col_a), 32'(col_m));
    endtask

    function automatic logic [15:0] pick_pc();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return BASE + 16'($urandom_range(0, DEPTH - 1));
        else if (r == 7) return BASE + 16'(DEPTH) + 16'($urandom_range(0, 1000));
        else if (r == 8) return BASE - 16'($urandom_range(1, 100));
        else             return BASE + 16'(DEPTH - 1);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, s, x;
        exp_t e;
        int   pulses_base;

        rst_a = 1'b1; rst_b = 1'b1;
        ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        bus_a.instrmem_rd = 1'b0; bus_a.pc = '0;
        bus_a.Data_rd = 1'b0; bus_a.Data_wr = 1'b0; bus_a.Data_addr = '0; bus_a.Data_din = '0;
        bus_b.instrmem_rd = 1'b0; bus_b.pc = '0;
        bus_b.Data_rd = 1'b0; bus_b.Data_wr = 1'b0; bus_b.Data_addr = '0; bus_b.Data_din = '0;
        @(posedge clk); #1;

        // Reset values.
        check("rst_a_instr_dout", 32'(bus_a.Instr_dout), 0);
        check("rst_a_data_dout", 32'(bus_a.Data_dout), 0);
        check("rst_a_complete_instr", 32'(bus_a.complete_instr), 0);
        check("rst_a_complete_data", 32'(bus_a.complete_data), 0);
        check("rst_a_oob_err", 32'(oob_a), 0);
        check("rst_a_col_err", 32'(col_a), 0);
        check("rst_a_instr_count", 32'(cnt_a), 0);
        check("rst_b_instr_dout", 32'(bus_b.Instr_dout), 0);
        check("rst_b_instr_count", 32'(cnt_b), 0);

        // Fill both arrays while reset is still high.
        for (int i = 0; i < DEPTH; i++) begin
            preload(1'b0, i, 16'($urandom));
            preload(1'b1, i, 16'($urandom));
        end
        rst_a = 1'b0; rst_b = 1'b0;
        reset_model(0);
        reset_model(1);

        // Single-cycle fetch of a preloaded word.
        preload(1'b0, 0, 16'h1021);
        fetch(0, 16'h3000);

        // Write then read back through the 3-cycle data port.
        data_op(1'b0, 1'b1, 16'h0005, 16'hBEEF);
        data_op(1'b1, 1'b0, 16'h0005, 16'h0000);

        // First index past the instruction array.
        fetch(0, BASE + 16'd256);

        // Read/write collision: read wins, word untouched.
        preload(1'b1, 2, 16'h0007);
        data_op(1'b1, 1'b1, 16'h0002, 16'h1234);
        data_op(1'b1, 1'b0, 16'hFF02, 16'h0000);

        // Request held high: one access per LAT+1 cycles, nothing sampled during RESP.
        @(posedge clk); #1;
        k = cyc;
        bus_a.instrmem_rd = 1'b1;
        bus_a.pc          = BASE + 16'd3;
        s = k + 1;
        while (s <= k + 6) begin
            x      = take_extra(0, s);
            e.due  = s + A_ILAT - 1 + x;
            e.dout = imem_m[3];
            sb[0].push_back(e);
            fetch_n[0]++;
            s = s + A_ILAT + x + 1;
        end
        repeat (6) @(posedge clk);
        #1;
        bus_a.instrmem_rd = 1'b0;
        repeat (12) @(negedge clk);
        check("held_req_count", 32'(cnt_a), 32'(16'(fetch_n[0])));

        // Randomized concurrent traffic on both ports of A.
        fork
            for (int i = 0; i < 30; i++) begin
                fetch(0, pick_pc());
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            for (int i = 0; i < 30; i++) begin
                int r;
                r = $urandom_range(0, 9);
                data_op(r < 4 || r >= 8, r >= 4, 16'($urandom), 16'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        join

        // B: reset two cycles after a 4-cycle fetch is sampled aborts it cleanly.
        preload(1'b0, 9, 16'h5A5A);
        pulses_base = b_pulses;
        bus_b.instrmem_rd = 1'b1;
        bus_b.pc          = BASE + 16'd9;
        void'(take_extra(1, cyc + 1));
        @(posedge clk); #1;
        bus_b.instrmem_rd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        #1;
        check("b_reset_complete", 32'(bus_b.complete_instr), 0);
        preload(1'b0, 10, 16'h6B6B);
        rst_b = 1'b0;
        reset_model(1);
        repeat (10) @(negedge clk);
        check("b_abort_pulses", 32'(b_pulses - pulses_base), 0);
        check("b_abort_count", 32'(cnt_b), 0);
        fetch(1, BASE + 16'd10);
        fetch(1, BASE + 16'd9);

        repeat (4) @(negedge clk);
        check("sb_a_fetch_drained", 32'(sb[0].size()), 0);
        check("sb_a_data_drained", 32'(sb[1].size()), 0);
        check("sb_b_fetch_drained", 32'(sb[2].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
